// File: rtl/pipe_ifid_queue.sv
//==============================================================================
// Module   : pipe_ifid_queue
// Brief    : First-word-fall-through instruction queue between IF and ID.
//            IF pushes {pc4, ins}; ID pops the head. in_ready doubles as the
//            PC-register write enable, so the PC advances only when a fetched
//            word is accepted. A redirect (flush) discards every entry.
//            Optional statistics counters are built when IFQ_STATS_EN is
//            defined (stall_cycles, flush_count outputs).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module pipe_ifid_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [31:0]   in_pc4,
  input  logic [31:0]   in_ins,
  output logic          in_ready,
  input  logic          flush,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [31:0]   out_pc4,
  output logic [31:0]   out_ins,
  output logic [AW:0]   count
`ifdef IFQ_STATS_EN
  ,
  output logic [31:0]   stall_cycles,
  output logic [15:0]   flush_count
`endif
);

  localparam logic [AW:0]   c_full    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_cnt_one = (AW+1)'(1);
  localparam logic [AW-1:0] c_ptr_one = AW'(1);

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q,  count_d;

  logic w_push;
  logic w_pop;
  logic w_nonempty;

  // Handshake decode: full blocks input with no pass-through, flush blocks both sides.
  always_comb begin
    w_nonempty = (count_q != '0);
    in_ready   = (count_q < c_full) & ~flush;
    out_valid  = w_nonempty & ~flush;
    w_push     = in_valid & in_ready;
    w_pop      = out_valid & out_ready;
    if (w_nonempty) begin
      out_pc4 = mem_q[rd_ptr_q][63:32];
      out_ins = mem_q[rd_ptr_q][31:0];
    end else begin
      out_pc4 = '0;
      out_ins = '0;
    end
    count = count_q;
  end

  // Next-state pointers and occupancy; flush wins over any push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + c_ptr_one;
      if (w_pop)  rd_ptr_d = rd_ptr_q + c_ptr_one;
      if (w_push && !w_pop)      count_d = count_q + c_cnt_one;
      else if (w_pop && !w_push) count_d = count_q - c_cnt_one;
    end
  end

  // Pointer and count registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clock) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= {in_pc4, in_ins};
    end
  end

`ifdef IFQ_STATS_EN
  logic [31:0] stall_q;
  logic [15:0] flushes_q;

  // Saturating counters of ID-stall cycles and redirect cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q   <= '0;
      flushes_q <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if (flush && (flushes_q != '1))                 flushes_q <= flushes_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flushes_q;
`endif

endmodule

`default_nettype wire
